// File: rtl/sram2rw_pkg.sv
// Shared widths, request/pin typedefs and the pin-drive helper for the
// two-port SRAM front end.
package sram2rw_pkg;

    localparam int SRAM_ADDR_W = 5;
    localparam int SRAM_DATA_W = 39;

    typedef struct packed {
        logic                   write;
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] wdata;
    } sram_req_t;

    typedef struct packed {
        logic                   csb;
        logic                   web;
        logic                   oeb;
        logic [SRAM_ADDR_W-1:0] a;
        logic [SRAM_DATA_W-1:0] i;
    } sram_pins_t;

    localparam sram_pins_t PINS_IDLE = '{csb: 1'b1, web: 1'b1, oeb: 1'b1, a: '0, i: '0};

    // Idle pins park address/data at zero so the macro sees no toggling.
    function automatic sram_pins_t pin_drive(input logic accept, input sram_req_t req);
        sram_pins_t p;
        p = PINS_IDLE;
        if (accept) begin
            p.csb = 1'b0;
            p.web = ~req.write;
            p.oeb = req.write;
            p.a   = req.addr;
            if (req.write) begin
                p.i = req.wdata;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/sram2rw_rsp_fifo.sv
// Per-port read-response FIFO: power-of-2 depth, simultaneous push/pop legal
// even when full (the caller's credit scheme guarantees a pop in that case).
module sram2rw_rsp_fifo #(
    parameter int DATA_W = 39,
    parameter int DEPTH  = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic                     head_valid,
    output logic [DATA_W-1:0]        head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W:0]    count_q;
    logic              do_pop;

    assign do_pop     = pop & (count_q != '0);
    assign head_valid = (count_q != '0);
    assign head_data  = mem_q[rd_ptr_q];
    assign count      = count_q;

    // Storage is cleared on reset so the response data bus reads zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sram2rw_port_ctrl.sv
// Two-channel valid/ready front end for a two-port 32x39 SRAM macro: pin drive,
// read-credit flow control, same-address collision resolution (port 1 wins).
module sram2rw_port_ctrl
    import sram2rw_pkg::*;
#(
    parameter int ADDR_W    = SRAM_ADDR_W,
    parameter int DATA_W    = SRAM_DATA_W,
    parameter int RSP_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_rdata,

    input  logic              req2_valid,
    output logic              req2_ready,
    input  logic              req2_write,
    input  logic [ADDR_W-1:0] req2_addr,
    input  logic [DATA_W-1:0] req2_wdata,
    output logic              rsp2_valid,
    input  logic              rsp2_ready,
    output logic [DATA_W-1:0] rsp2_rdata,

    output logic              mem_CE1,
    output logic              mem_CSB1,
    output logic              mem_WEB1,
    output logic              mem_OEB1,
    output logic [ADDR_W-1:0] mem_A1,
    output logic [DATA_W-1:0] mem_I1,
    input  logic [DATA_W-1:0] mem_O1,

    output logic              mem_CE2,
    output logic              mem_CSB2,
    output logic              mem_WEB2,
    output logic              mem_OEB2,
    output logic [ADDR_W-1:0] mem_A2,
    output logic [DATA_W-1:0] mem_I2,
    input  logic [DATA_W-1:0] mem_O2
);

    localparam int CNT_W = $clog2(RSP_DEPTH) + 1;

    logic             run_q;
    logic             inflight1_q, inflight2_q;
    logic [CNT_W-1:0] count1, count2;
    logic [CNT_W:0]   used1, used2;
    logic             pop1, pop2, credit1, credit2, collide, acc1, acc2;
    sram_pins_t       pins1, pins2;

    // Ready is held low until the first edge after reset release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            run_q       <= 1'b0;
            inflight1_q <= 1'b0;
            inflight2_q <= 1'b0;
        end else begin
            run_q       <= 1'b1;
            inflight1_q <= acc1 & ~req1_write;
            inflight2_q <= acc2 & ~req2_write;
        end
    end

    // Credits count in-flight reads so a full FIFO can still absorb the push
    // that lands in the same cycle as a pop.
    always_comb begin
        pop1       = rsp1_valid & rsp1_ready;
        pop2       = rsp2_valid & rsp2_ready;
        used1      = {1'b0, count1} + (CNT_W+1)'(inflight1_q) - (CNT_W+1)'(pop1);
        used2      = {1'b0, count2} + (CNT_W+1)'(inflight2_q) - (CNT_W+1)'(pop2);
        credit1    = used1 < (CNT_W+1)'(RSP_DEPTH);
        credit2    = used2 < (CNT_W+1)'(RSP_DEPTH);
        collide    = req1_valid & (req1_addr == req2_addr) & (req1_write | req2_write);
        req1_ready = run_q & (req1_write | credit1);
        req2_ready = run_q & ~collide & (req2_write | credit2);
        acc1       = req1_valid & req1_ready;
        acc2       = req2_valid & req2_ready;
        pins1      = pin_drive(acc1, sram_req_t'{write: req1_write, addr: req1_addr, wdata: req1_wdata});
        pins2      = pin_drive(acc2, sram_req_t'{write: req2_write, addr: req2_addr, wdata: req2_wdata});
    end

    assign mem_CE1  = clock;
    assign mem_CSB1 = pins1.csb;
    assign mem_WEB1 = pins1.web;
    assign mem_OEB1 = pins1.oeb;
    assign mem_A1   = pins1.a;
    assign mem_I1   = pins1.i;

    assign mem_CE2  = clock;
    assign mem_CSB2 = pins2.csb;
    assign mem_WEB2 = pins2.web;
    assign mem_OEB2 = pins2.oeb;
    assign mem_A2   = pins2.a;
    assign mem_I2   = pins2.i;

    sram2rw_rsp_fifo #(.DATA_W(DATA_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo1 (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (inflight1_q),
        .push_data  (mem_O1),
        .pop        (pop1),
        .head_valid (rsp1_valid),
        .head_data  (rsp1_rdata),
        .count      (count1)
    );

    sram2rw_rsp_fifo #(.DATA_W(DATA_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo2 (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (inflight2_q),
        .push_data  (mem_O2),
        .pop        (pop2),
        .head_valid (rsp2_valid),
        .head_data  (rsp2_rdata),
        .count      (count2)
    );

endmodule

// File: doc/sram2rw_port_ctrl.md
# sram2rw_port_ctrl

Two-channel request/response front end that drives a two-port read/write SRAM macro (32 words x 39 bits, per-port address/chip-select/write-enable/output-enable, data registered on the rising clock edge). Each port converts a valid/ready request stream into macro pin activity. It captures read data into a small response FIFO so back-pressure is safe. It also resolves same-address collisions between the two ports. It sits between cache/tag logic and the SRAM macro instance.

## Interface
- ADDR_W, 5, macro address width
- DATA_W, 39, macro word width
- RSP_DEPTH, 2, response FIFO entries per port (power of 2, >=2)
- clock  in  1  single clock for all logic; forwarded to the macro
- reset_n  in  1  asynchronous, active-low reset
- reqN_valid / reqN_ready  in/out  1  request handshake, N in {1,2}
- reqN_write  in  1  1 = write, 0 = read
- reqN_addr  in  ADDR_W  word address
- reqN_wdata  in  DATA_W  write data
- rspN_valid / rspN_ready  out/in  1  read-response handshake
- rspN_rdata  out  DATA_W  read data
- mem_CEN  out  1  macro clock, equal to clock
- mem_CSBN, mem_WEBN, mem_OEBN  out  1  macro active-low selects
- mem_AN  out  ADDR_W  macro address
- mem_IN  out  DATA_W  macro write data
- mem_ON  in  DATA_W  macro read data, valid after the edge that sampled the read

## Operation
- Accept on port N means reqN_valid & reqN_ready. The accepted request drives the macro pins combinationally in the same cycle, and the macro samples it at the closing edge.
- Accepted read: CSB=0, OEB=0, WEB=1. Accepted write: CSB=0, WEB=0, OEB=1. With no accept: CSB=WEB=OEB=1, A=0, I=0.
- Write: produces no response. reqN_ready for a write ignores FIFO state.
- Read: sets an in-flight flag for port N. On the next cycle, mem_ON is pushed into the port-N response FIFO. rspN_* presents the FIFO head.
- Read credit: reqN_ready for a read is 1 only when (FIFO count + in-flight) < RSP_DEPTH. A FIFO pop in the same cycle frees a credit.
- Collision: both ports valid, same address, and at least one is a write. Port 1 wins; req2_ready=0 in that cycle. Two reads to the same address do not collide.
- Ready may depend combinationally on the other port's valid/addr/write. It never depends on its own valid.
- Ports are otherwise independent. Per-port response order equals request order.

## Timing
- Read latency: accept at edge t, FIFO push at edge t+1, rspN_valid=1 in the cycle after edge t+1 (2 cycles). No bypass path.
- Write visible to a read on either port accepted at edge t+1 or later.
- Throughput: 1 read per port per cycle while rspN_ready=1. With RSP_DEPTH=2, a stalled consumer sees exactly two accepted reads before ready drops.
- Simultaneous push and pop on a full FIFO: both succeed, count unchanged. This is legal only because the credit rule counts in-flight reads.
- Reset (reset_n=0, asynchronous):
  - FIFOs empty, in-flight flags clear.
  - rspN_valid=0, reqN_ready=0.
  - mem_CSBN/WEBN/OEBN=1, mem_AN=0, mem_IN=0, rspN_rdata=0.
- Reset mid-operation drops in-flight reads, with no response after release. Macro contents are not cleared.
- reqN_ready rises in the first cycle after reset_n deasserts.

## Structure
- Package sram2rw_pkg: ADDR_W/DATA_W defaults, a request struct typedef (write, addr, wdata), and a typedef for the macro pin bundle per port.
- Sub-module sram2rw_rsp_fifo, instantiated once per port. It is a synchronous FIFO with push/pop/count, RSP_DEPTH entries and async active-low reset.
- Top level holds the credit logic, collision logic and pin drive.

## Test plan
- Port 1 writes 0x7F_FFFF_FFFF to addr 3; port 2 reads addr 3 one cycle later -> rsp2_rdata=0x7F_FFFF_FFFF, rsp2_valid 2 cycles after its accept.
- rsp1_ready=0 with port 1 issuing reads to addr 0,1,2 -> two accepts, req1_ready=0 on the third. Raise rsp1_ready -> addr 0 then 1 data in order, then addr 2 accepted.
- Same cycle, port 1 writes addr 5 and port 2 reads addr 5 -> req2_ready=0. Port 2 is accepted next cycle and returns the newly written data.
- Same cycle, both ports read addr 9 -> both accepted, both return identical data at latency 2.
- Assert reset_n=0 one cycle after a read accept -> rsp_valid stays 0 after release. FIFOs are empty and mem_CSB1=mem_CSB2=1 during reset.
- Random mixed traffic on both ports against a reference memory model, with random rsp_ready -> all data matches, no FIFO overflow, per-port order preserved.
